cc_rdata_arbiter: RTL and testbench
===================================

# cc_rdata_arbiter

Burst-level scheduler sharing the single 64-bit cache read-data return channel between two 518-bit line-data FIFOs: hit data (source 0) and miss refill (source 1). Picks one non-empty source per burst by round-robin and pops its entry into a local line buffer. Returns the 8 words of the line critical-word-first with a full valid/ready handshake. It sits between the two line FIFOs and the AXI-style R channel, replacing direct FIFO-to-serializer wiring.

## Interface
- DATA_W, 64, beat width
- BEATS, 8, beats per line (line = DATA_W*BEATS = 512 bits)
- ENTRY_W, 518, FIFO entry width; [517:512] offset field, [517:515] critical word index, [511:0] line
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- src0_empty_i  in  1  hit FIFO empty; FIFO is first-word-fall-through
- src0_rdata_i  in  ENTRY_W  hit FIFO head entry
- src0_rden_o  out  1  hit FIFO pop
- src1_empty_i  in  1  refill FIFO empty
- src1_rdata_i  in  ENTRY_W  refill FIFO head entry
- src1_rden_o  out  1  refill FIFO pop
- rdata_o  out  DATA_W  return beat
- rlast_o  out  1  final beat of burst
- rvalid_o  out  1  beat valid
- rid_o  out  1  source of current burst (0 hit, 1 refill)
- rready_i  in  1  consumer accepts beat

## Operation
- FSM: IDLE, BURST.
- Arbitration (IDLE, or BURST on final handshake): candidates = sources with empty_i low. One candidate: grant it. Both: grant the source not served last (rr pointer). rr pointer resets to 1, so source 0 wins the first tie.
- Grant: srcN_rden_o = 1 for exactly that cycle (combinational from empty_i and state); head entry latched into line buffer; crit <= entry[517:515]; beat <= 0; rid <= N; rr pointer <= N; state -> BURST.
- BURST: rvalid_o = 1; word index = (crit + beat) mod 8, 3-bit wrapping add; word k = line[511-64k -: 64], word 0 = MSBs; rlast_o = (beat == 7).
- Handshake: beat advances only on rvalid_o & rready_i. While rready_i is low, rdata_o/rlast_o/rid_o hold stable.
- Final handshake (beat 7 accepted): if any source non-empty, re-arbitrate the same cycle and stay in BURST (no bubble). Else -> IDLE, rvalid_o = 0.
- Never pops both sources in one cycle. Never pops while a burst has beats outstanding.
- Line buffer offset bits [514:512] ignored.

## Timing
- Reset values: rvalid_o 0, rlast_o 0, rdata_o 0, rid_o 0, src0_rden_o 0, src1_rden_o 0; state IDLE; beat 0; buffer 0.
- Latency: empty_i low in IDLE at cycle t -> rden_o high at t -> first beat valid at t+1.
- Burst with rready_i held high: 8 consecutive valid cycles. Back-to-back bursts: 16 contiguous valid cycles. The second pop coincides with the 8th beat.
- rdata_o, rlast_o, rvalid_o, rid_o come only from registers: no combinational path from any input. rden_o is the only combinational output.
- empty_i rising in the grant cycle is not re-sampled; the entry is already committed.
- Reset mid-burst: burst abandoned; outputs take reset values the cycle after rst_n is sampled low; the popped entry is lost.

## Structure
- Shared package cc_pkg holds:
  - constants DATA_W, BEATS, ENTRY_W, CRIT_MSB/CRIT_LSB;
  - enum cc_arb_state_t {IDLE, BURST}.
- Sub-module cc_rr_arbiter2: 2-request round-robin arbiter.
  - Inputs: req[1:0], last_grant, update.
  - Outputs: one-hot gnt[1:0], gnt_valid.
  - Reused later for write-response arbitration.
- Top holds the FSM, beat counter, line buffer and word mux.

## Test plan
- Single hit entry, offset 3'd5, rready_i high: rden0 one pulse. Beats carry words 5,6,7,0,1,2,3,4 on 8 consecutive cycles, rlast_o on the 8th only, rid_o 0.
- Both FIFOs hold 2 entries each from reset: burst order rid 0,1,0,1. 32 contiguous valid cycles, no bubbles. Each rden exactly 2 pulses.
- rready_i random at 50%, offset 3'd7: the beat sequence stays 7,0..6. Outputs stable while rready_i low. Exactly 8 handshakes, rlast_o only on the 8th.
- Refill only, offset 3'd0, rready_i low for 10 cycles after first valid: no second pop and no state change. Then rready_i high: word 0 delivered first.
- Reset at beat 3 of a burst with source 1 non-empty: rvalid_o 0 the next cycle, rid_o 0. After release, source 1 is re-granted with a fresh burst starting at beat 0.
- FIFOs empty after reset for 20 cycles: rvalid_o and both rden_o stay 0.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared constants and types for the cache read-data return path.
package cc_pkg;

  localparam int DATA_W   = 64;
  localparam int BEATS    = 8;
  localparam int BEAT_W   = $clog2(BEATS);
  localparam int LINE_W   = DATA_W * BEATS;
  localparam int ENTRY_W  = 518;
  localparam int CRIT_MSB = 517;
  localparam int CRIT_LSB = 515;

  typedef enum logic {
    IDLE,
    BURST
  } cc_arb_state_t;

endpackage

// File: rtl/cc_rr_arbiter2.sv
// Two-requester round-robin arbiter; the caller owns the last-grant pointer.
module cc_rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       update_i,
  output logic [1:0] gnt_o,
  output logic       gnt_valid_o
);

  logic pick;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick        = (req_i == 2'b11) ? ~last_grant_i : req_i[1];
    gnt_valid_o = update_i & (|req_i);
    gnt_o       = 2'b00;
    if (gnt_valid_o) begin
      gnt_o = pick ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/cc_rdata_arbiter.sv
// Schedules whole-line bursts from the hit and refill FIFOs onto the 64-bit R channel,
// returning each line critical-word-first.
module cc_rdata_arbiter
  import cc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               src0_empty_i,
  input  logic [ENTRY_W-1:0] src0_rdata_i,
  output logic               src0_rden_o,
  input  logic               src1_empty_i,
  input  logic [ENTRY_W-1:0] src1_rdata_i,
  output logic               src1_rden_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               rlast_o,
  output logic               rvalid_o,
  output logic               rid_o,
  input  logic               rready_i
);

  cc_arb_state_t      state_q;
  logic [LINE_W-1:0]  lineBuf_q;
  logic [BEAT_W-1:0]  crit_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [BEAT_W-1:0]  beat_d;
  logic [BEAT_W-1:0]  wordIdx;
  logic               rid_q;
  logic               rrPtr_q;
  logic [1:0]         req;
  logic [1:0]         gnt;
  logic               gntValid;
  logic               canArb;
  logic               lastBeat;
  logic [LINE_W-1:0]  headLine;
  logic [BEAT_W-1:0]  headCrit;
  logic [DATA_W-1:0]  wordMux;
  logic               unusedOffset;

  assign lastBeat = (beat_q == BEAT_W'(BEATS - 1));
  assign beat_d   = beat_q + BEAT_W'(1);
  assign wordIdx  = crit_q + beat_q;

  // Arbitrate when idle or on the final accepted beat, so back-to-back bursts have no bubble.
  assign canArb = rst_n & ((state_q == IDLE) |
                           ((state_q == BURST) & rready_i & lastBeat));
  assign req    = {~src1_empty_i, ~src0_empty_i};

  cc_rr_arbiter2 u_arb (
    .req_i        (req),
    .last_grant_i (rrPtr_q),
    .update_i     (canArb),
    .gnt_o        (gnt),
    .gnt_valid_o  (gntValid)
  );

  assign src0_rden_o = gnt[0];
  assign src1_rden_o = gnt[1];

  assign headLine = gnt[1] ? src1_rdata_i[LINE_W-1:0] : src0_rdata_i[LINE_W-1:0];
  assign headCrit = gnt[1] ? src1_rdata_i[CRIT_MSB:CRIT_LSB]
                           : src0_rdata_i[CRIT_MSB:CRIT_LSB];

  // The low offset bits carry nothing this block needs.
  assign unusedOffset = ^{src0_rdata_i[CRIT_LSB-1:LINE_W], src1_rdata_i[CRIT_LSB-1:LINE_W]};

  always_comb begin
    wordMux = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (wordIdx == BEAT_W'(k)) begin
        wordMux = lineBuf_q[LINE_W-1-DATA_W*k -: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lineBuf_q <= '0;
      crit_q    <= '0;
      beat_q    <= '0;
      rid_q     <= 1'b0;
      rrPtr_q   <= 1'b1;
    end else if (gntValid) begin
      state_q   <= BURST;
      lineBuf_q <= headLine;
      crit_q    <= headCrit;
      beat_q    <= '0;
      rid_q     <= gnt[1];
      rrPtr_q   <= gnt[1];
    end else if ((state_q == BURST) && rready_i) begin
      beat_q <= beat_d;
      if (lastBeat) begin
        state_q <= IDLE;
      end
    end
  end

  assign rvalid_o = (state_q == BURST);
  assign rlast_o  = (state_q == BURST) & lastBeat;
  assign rid_o    = rid_q;
  assign rdata_o  = wordMux;

endmodule

// File: tb/tb_cc_rdata_arbiter.sv
// Randomized bench for cc_rdata_arbiter: queue-based FIFOs plus a burst-level reference model.
module tb_cc_rdata_arbiter;

  logic         clk;
  logic         rst_n;
  logic         src0_empty_i;
  logic [517:0] src0_rdata_i;
  logic         src0_rden_o;
  logic         src1_empty_i;
  logic [517:0] src1_rdata_i;
  logic         src1_rden_o;
  logic [63:0]  rdata_o;
  logic         rlast_o;
  logic         rvalid_o;
  logic         rid_o;
  logic         rready_i;

  cc_rdata_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src0_empty_i (src0_empty_i),
    .src0_rdata_i (src0_rdata_i),
    .src0_rden_o  (src0_rden_o),
    .src1_empty_i (src1_empty_i),
    .src1_rdata_i (src1_rdata_i),
    .src1_rden_o  (src1_rden_o),
    .rdata_o      (rdata_o),
    .rlast_o      (rlast_o),
    .rvalid_o     (rvalid_o),
    .rid_o        (rid_o),
    .rready_i     (rready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [517:0] fifo0[$];
  logic [517:0] fifo1[$];

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: the burst in flight as a list of eight expected words.
  bit          mBusy    = 0;
  int          mIdx     = 0;
  bit          mRid     = 0;
  bit          mLast    = 1;
  bit          mCleared = 1;
  logic [63:0] mWords[8];

  bit           rstCtl      = 0;
  int           readyMode   = 0;
  bit           randomPush  = 0;
  int           rden0Count  = 0;
  int           rden1Count  = 0;
  int           validCount  = 0;
  int           hsCount     = 0;
  int           lastHsCount = 0;
  int           lastHsBeat  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s observed %h expected %h at %0t", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic pushEntry(input int src, input int crit);
    logic [511:0] line;
    logic [517:0] entry;
    for (int i = 0; i < 16; i++) line[i*32 +: 32] = $urandom();
    entry = {3'(crit), 3'($urandom_range(0, 7)), line};
    if (src == 0) fifo0.push_back(entry);
    else fifo1.push_back(entry);
  endtask

  task automatic clearCounters();
    rden0Count  = 0;
    rden1Count  = 0;
    validCount  = 0;
    hsCount     = 0;
    lastHsCount = 0;
    lastHsBeat  = 0;
  endtask

  // One clock: drive at negedge, compare against the model, then advance model and FIFOs.
  task automatic stepCycle();
    bit           sRst, sReady, sGrant, sSrc, obsR0, obsR1;
    logic [517:0] sEntry;
    logic [511:0] line;
    logic [511:0] shifted;
    int           crit;
    int           w;

    @(negedge clk);
    rst_n = rstCtl;
    if (readyMode == 0) rready_i = 1'b1;
    else if (readyMode == 1) rready_i = 1'($urandom_range(0, 1));
    else rready_i = 1'b0;
    if (randomPush) begin
      if ($urandom_range(0, 3) == 0 && fifo0.size() < 4) pushEntry(0, $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0 && fifo1.size() < 4) pushEntry(1, $urandom_range(0, 7));
    end
    src0_empty_i = (fifo0.size() == 0);
    src0_rdata_i = (fifo0.size() != 0) ? fifo0[0] : '0;
    src1_empty_i = (fifo1.size() == 0);
    src1_rdata_i = (fifo1.size() != 0) ? fifo1[0] : '0;
    #1;

    sRst   = rst_n;
    sReady = rready_i;
    sGrant = sRst && (!mBusy || (sReady && mIdx == 7)) &&
             (fifo0.size() != 0 || fifo1.size() != 0);
    if (fifo0.size() == 0) sSrc = 1;
    else if (fifo1.size() == 0) sSrc = 0;
    else sSrc = !mLast;
    sEntry = '0;
    if (sGrant) sEntry = sSrc ? fifo1[0] : fifo0[0];

    checkOutput("rden0", src0_rden_o, sGrant && !sSrc);
    checkOutput("rden1", src1_rden_o, sGrant && sSrc);
    checkOutput("rvalid", rvalid_o, mBusy);
    checkOutput("rid", rid_o, mRid);
    if (mBusy) begin
      checkOutput("rdata", rdata_o, mWords[mIdx]);
      checkOutput("rlast", rlast_o, mIdx == 7);
    end else begin
      checkOutput("rlast_idle", rlast_o, 0);
      if (mCleared) checkOutput("rdata_reset", rdata_o, 0);
    end

    obsR0 = src0_rden_o;
    obsR1 = src1_rden_o;
    if (obsR0) rden0Count++;
    if (obsR1) rden1Count++;
    if (rvalid_o) validCount++;
    if (rvalid_o && sReady) begin
      hsCount++;
      if (rlast_o) begin
        lastHsCount++;
        lastHsBeat = hsCount;
      end
    end

    @(posedge clk);
    #1;
    if (obsR0 && fifo0.size() != 0) void'(fifo0.pop_front());
    if (obsR1 && fifo1.size() != 0) void'(fifo1.pop_front());

    if (!sRst) begin
      mBusy    = 0;
      mIdx     = 0;
      mRid     = 0;
      mLast    = 1;
      mCleared = 1;
    end else begin
      if (mBusy && sReady) begin
        if (mIdx == 7) mBusy = 0;
        mIdx++;
      end
      if (sGrant) begin
        line = sEntry[511:0];
        crit = int'(sEntry[517:515]);
        for (int k = 0; k < 8; k++) begin
          w        = (crit + k) % 8;
          shifted  = line >> (64 * (7 - w));
          mWords[k] = shifted[63:0];
        end
        mBusy    = 1;
        mIdx     = 0;
        mRid     = sSrc;
        mLast    = sSrc;
        mCleared = 0;
      end
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) stepCycle();
  endtask

  initial begin
    int guard;
    rst_n        = 1'b0;
    rready_i     = 1'b0;
    src0_empty_i = 1'b1;
    src1_empty_i = 1'b1;
    src0_rdata_i = '0;
    src1_rdata_i = '0;

    $display("[TB] reset, then idle with empty FIFOs");
    rstCtl = 0;
    applyStimulus(3);
    rstCtl = 1;
    clearCounters();
    applyStimulus(20);
    checkOutput("idle_valid_cnt", validCount, 0);
    checkOutput("idle_rden_cnt", rden0Count + rden1Count, 0);

    $display("[TB] single hit entry, critical word 5");
    pushEntry(0, 5);
    clearCounters();
    applyStimulus(12);
    checkOutput("single_rden0_cnt", rden0Count, 1);
    checkOutput("single_valid_cnt", validCount, 8);
    checkOutput("single_last_beat", lastHsBeat, 8);

    $display("[TB] two entries per FIFO, back to back");
    for (int i = 0; i < 2; i++) begin
      pushEntry(0, $urandom_range(0, 7));
      pushEntry(1, $urandom_range(0, 7));
    end
    clearCounters();
    applyStimulus(40);
    checkOutput("b2b_rden0_cnt", rden0Count, 2);
    checkOutput("b2b_rden1_cnt", rden1Count, 2);
    checkOutput("b2b_valid_cnt", validCount, 32);
    checkOutput("b2b_last_cnt", lastHsCount, 4);

    $display("[TB] random backpressure, critical word 7");
    pushEntry(0, 7);
    readyMode = 1;
    clearCounters();
    stepCycle();
    guard = 0;
    while (mBusy && guard < 200) begin
      stepCycle();
      guard++;
    end
    checkOutput("bp_done_valid", rvalid_o, 0);
    checkOutput("bp_hs_cnt", hsCount, 8);
    checkOutput("bp_last_cnt", lastHsCount, 1);
    checkOutput("bp_last_beat", lastHsBeat, 8);

    $display("[TB] refill held off by rready low");
    pushEntry(1, 0);
    pushEntry(1, 3);
    readyMode = 2;
    clearCounters();
    applyStimulus(11);
    checkOutput("stall_rden1_cnt", rden1Count, 1);
    readyMode = 0;
    applyStimulus(24);
    checkOutput("stall_rden1_total", rden1Count, 2);

    $display("[TB] reset in the middle of a burst");
    pushEntry(1, 2);
    pushEntry(1, 6);
    applyStimulus(4);
    rstCtl = 0;
    applyStimulus(1);
    rstCtl = 1;
    clearCounters();
    applyStimulus(12);
    checkOutput("rst_regrant_cnt", rden1Count, 1);

    $display("[TB] randomized traffic");
    randomPush = 1;
    readyMode  = 1;
    applyStimulus(400);
    randomPush = 0;
    readyMode  = 0;
    applyStimulus(120);
    checkOutput("drain_fifo0", fifo0.size(), 0);
    checkOutput("drain_fifo1", fifo1.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
